// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: redirect/stall control, instruction-memory port and the IF/ID register view.
interface fetch_stage_if;
  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;

  logic            stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;
  logic [XLEN-1:0] imem_addr;
  logic [ILEN-1:0] imem_rdata;
  logic            if_id_valid;
  logic [XLEN-1:0] if_id_pc;
  logic [XLEN-1:0] if_id_pc_plus4;
  logic [ILEN-1:0] if_id_instruction;
  logic            fetch_misaligned;

  modport master (
    input  stall, redirect_valid, redirect_target, imem_rdata,
    output imem_addr, if_id_valid, if_id_pc, if_id_pc_plus4, if_id_instruction, fetch_misaligned
  );

  modport slave (
    output stall, redirect_valid, redirect_target, imem_rdata,
    input  imem_addr, if_id_valid, if_id_pc, if_id_pc_plus4, if_id_instruction, fetch_misaligned
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch and IF/ID register: owns the PC, folds B/BL in fetch, takes EX redirects and hazard stalls.
module fetch_stage #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter logic [31:0] NOP_INSTR = 32'hD503201F
) (
  input logic          clock,
  input logic          reset,
  fetch_stage_if.master bus
);
  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;
  localparam int unsigned IMMW = 26;
  localparam logic [5:0]  OP_B  = 6'b000101;
  localparam logic [5:0]  OP_BL = 6'b100101;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] b_offset;
  logic [XLEN-1:0] b_target;
  logic            uncond_b;

  logic            if_id_valid;
  logic [XLEN-1:0] if_id_pc;
  logic [XLEN-1:0] if_id_pc_plus4;
  logic [ILEN-1:0] if_id_instruction;
  logic            fetch_misaligned;

  // Early decode of unconditional B/BL on the word currently being fetched
  always_comb begin
    pc_plus4 = pc + XLEN'(4);
    b_offset = {{(XLEN-IMMW-2){bus.imem_rdata[IMMW-1]}}, bus.imem_rdata[IMMW-1:0], 2'b00};
    b_target = pc + b_offset;
    uncond_b = (bus.imem_rdata[31:26] == OP_B) || (bus.imem_rdata[31:26] == OP_BL);
  end

  // PC and IF/ID update; redirect overrides stall so a flush never waits
  always_ff @(posedge clock) begin
    if (reset) begin
      pc                <= RESET_PC;
      if_id_valid       <= 1'b0;
      if_id_pc          <= '0;
      if_id_pc_plus4    <= '0;
      if_id_instruction <= NOP_INSTR;
      fetch_misaligned  <= 1'b0;
    end else if (bus.redirect_valid) begin
      pc                <= {bus.redirect_target[XLEN-1:2], 2'b00};
      if_id_valid       <= 1'b0;
      if_id_instruction <= NOP_INSTR;
      if (bus.redirect_target[1:0] != 2'b00) fetch_misaligned <= 1'b1;
    end else if (!bus.stall) begin
      pc                <= uncond_b ? b_target : pc_plus4;
      if_id_valid       <= 1'b1;
      if_id_pc          <= pc;
      if_id_pc_plus4    <= pc_plus4;
      if_id_instruction <= bus.imem_rdata;
    end
  end

  assign bus.imem_addr         = pc;
  assign bus.if_id_valid       = if_id_valid;
  assign bus.if_id_pc          = if_id_pc;
  assign bus.if_id_pc_plus4    = if_id_pc_plus4;
  assign bus.if_id_instruction = if_id_instruction;
  assign bus.fetch_misaligned  = fetch_misaligned;
endmodule
